// File: rtl/mvau_pkg.sv
// Shared MVAU definitions: replay-buffer state encoding and address-width helper.
package mvau_pkg;

  typedef enum logic {WRITE, READ} inp_buf_state_t;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvau_inp_buf_mem.sv
// SF x TI activation store: synchronous write port, asynchronous read port.
module mvau_inp_buf_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mvau_inp_replay_buffer.sv
// Input-activation buffer: forwards one SF-word vector while storing it, then
// replays it NF-1 more times so every PE row-fold sees the same activations.
//
// state | meaning
// WRITE | pass-through of the input stream, each transferred word is stored
// READ  | replay of the stored vector for folds 1..NF-1, input stalled
module mvau_inp_replay_buffer
  import mvau_pkg::*;
#(
  parameter int SIMD    = 2,
  parameter int TSRCI   = 4,
  parameter int MATRIXW = 16,
  parameter int MATRIXH = 8,
  parameter int PE      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_v,
  input  logic [SIMD*TSRCI-1:0]  in,
  output logic                   in_rdy,
  output logic                   out_v,
  output logic [SIMD*TSRCI-1:0]  out,
  output logic                   out_last,
  output logic                   out_vec_last,
  input  logic                   out_rdy
);

  localparam int TI       = SIMD * TSRCI;
  localparam int SF       = MATRIXW / SIMD;
  localparam int NF       = MATRIXH / PE;
  localparam int BUF_ADDR = clog2_min1(SF);
  localparam int NF_W     = clog2_min1(NF);

  localparam logic [BUF_ADDR-1:0] SF_LAST = BUF_ADDR'(SF - 1);
  localparam logic [NF_W-1:0]     NF_LAST = NF_W'(NF - 1);

  inp_buf_state_t      state, state_nxt;
  logic [BUF_ADDR-1:0] sf_cnt, sf_nxt;
  logic [NF_W-1:0]     nf_cnt, nf_nxt;
  logic                we;
  logic                adv;
  logic [TI-1:0]       rdata;
  logic                sf_end;
  logic                nf_end;

  assign sf_end = (sf_cnt == SF_LAST);
  assign nf_end = (nf_cnt == NF_LAST);

  mvau_inp_buf_mem #(
    .DEPTH (SF),
    .AW    (BUF_ADDR),
    .W     (TI)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (sf_cnt),
    .wdata (in),
    .raddr (sf_cnt),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= WRITE;
      sf_cnt <= '0;
      nf_cnt <= '0;
    end else begin
      state  <= state_nxt;
      sf_cnt <= sf_nxt;
      nf_cnt <= nf_nxt;
    end
  end

  // Handshake outputs are gated by rst_n so nothing is offered or accepted in reset.
  always_comb begin
    state_nxt = state;
    sf_nxt    = sf_cnt;
    nf_nxt    = nf_cnt;
    in_rdy    = 1'b0;
    out_v     = 1'b0;
    out       = in;
    we        = 1'b0;
    adv       = 1'b0;

    if (rst_n) begin
      unique case (state)
        WRITE: begin
          in_rdy = out_rdy;
          out_v  = in_v;
          out    = in;
          we     = in_v & out_rdy;
          adv    = in_v & out_rdy;
        end
        READ: begin
          out_v = 1'b1;
          out   = rdata;
          adv   = out_rdy;
        end
        default: ;
      endcase
    end

    if (adv) begin
      if (sf_end) begin
        sf_nxt = '0;
        if (state == WRITE) begin
          if (NF > 1) begin
            nf_nxt    = NF_W'(1);
            state_nxt = READ;
          end
        end else if (nf_end) begin
          nf_nxt    = '0;
          state_nxt = WRITE;
        end else begin
          nf_nxt = nf_cnt + NF_W'(1);
        end
      end else begin
        sf_nxt = sf_cnt + BUF_ADDR'(1);
      end
    end
  end

  assign out_last     = out_v & sf_end;
  assign out_vec_last = out_last & nf_end;

endmodule

// File: tb/tb_mvau_inp_replay_buffer.sv
// Self-checking bench: three buffer configurations against a position-in-vector reference model.
module tb_mvau_inp_replay_buffer;

  localparam int SF_T [3] = '{4, 4, 1};
  localparam int NF_T [3] = '{3, 1, 4};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_v    [3];
  logic [7:0] din     [3];
  logic       in_rdy  [3];
  logic       out_v   [3];
  logic [7:0] dout    [3];
  logic       last    [3];
  logic       vlast   [3];
  logic       out_rdy [3];

  int checks   = 0;
  int failures = 0;

  int         pos     [3];
  logic [7:0] vec     [3][4];
  int         cnt_out [3];
  int         cnt_in  [3];
  int         cnt_vl  [3];

  logic [7:0] w1 [4];
  logic [7:0] w2 [4];

  always #5 clk = ~clk;

  // A: SF=4 NF=3, B: SF=4 NF=1, C: SF=1 NF=4
  mvau_inp_replay_buffer #(.SIMD(2), .TSRCI(4), .MATRIXW(8), .MATRIXH(6), .PE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_v(in_v[0]), .in(din[0]), .in_rdy(in_rdy[0]),
    .out_v(out_v[0]), .out(dout[0]), .out_last(last[0]), .out_vec_last(vlast[0]),
    .out_rdy(out_rdy[0]));

  mvau_inp_replay_buffer #(.SIMD(2), .TSRCI(4), .MATRIXW(8), .MATRIXH(2), .PE(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_v(in_v[1]), .in(din[1]), .in_rdy(in_rdy[1]),
    .out_v(out_v[1]), .out(dout[1]), .out_last(last[1]), .out_vec_last(vlast[1]),
    .out_rdy(out_rdy[1]));

  mvau_inp_replay_buffer #(.SIMD(2), .TSRCI(4), .MATRIXW(2), .MATRIXH(8), .PE(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_v(in_v[2]), .in(din[2]), .in_rdy(in_rdy[2]),
    .out_v(out_v[2]), .out(dout[2]), .out_last(last[2]), .out_vec_last(vlast[2]),
    .out_rdy(out_rdy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: each vector is SF*NF output words; the first SF are live pass-through,
  // the rest repeat the captured words in order.
  task automatic model_step(input int i);
    int  sf, nf, p;
    bit  live;
    sf = SF_T[i];
    nf = NF_T[i];
    if (!rst_n) begin
      check($sformatf("d%0d_rst_out_v", i), 32'(out_v[i]), 0);
      check($sformatf("d%0d_rst_in_rdy", i), 32'(in_rdy[i]), 0);
      check($sformatf("d%0d_rst_last", i), 32'(last[i]), 0);
      check($sformatf("d%0d_rst_vlast", i), 32'(vlast[i]), 0);
      pos[i] = 0;
      return;
    end
    p    = pos[i] % sf;
    live = (pos[i] < sf);
    if (live) begin
      check($sformatf("d%0d_w_out_v", i), 32'(out_v[i]), 32'(in_v[i]));
      check($sformatf("d%0d_w_in_rdy", i), 32'(in_rdy[i]), 32'(out_rdy[i]));
      if (in_v[i]) check($sformatf("d%0d_w_out", i), 32'(dout[i]), 32'(din[i]));
    end else begin
      check($sformatf("d%0d_r_out_v", i), 32'(out_v[i]), 1);
      check($sformatf("d%0d_r_in_rdy", i), 32'(in_rdy[i]), 0);
      check($sformatf("d%0d_r_out", i), 32'(dout[i]), 32'(vec[i][p]));
    end
    if (out_v[i]) begin
      check($sformatf("d%0d_last", i), 32'(last[i]), 32'(p == sf - 1));
      check($sformatf("d%0d_vlast", i), 32'(vlast[i]), 32'(pos[i] == sf * nf - 1));
    end
    if (in_v[i] && in_rdy[i]) cnt_in[i]++;
    if (out_v[i] && out_rdy[i]) begin
      cnt_out[i]++;
      if (vlast[i]) cnt_vl[i]++;
      if (live) vec[i][p] = din[i];
      pos[i] = (pos[i] + 1) % (sf * nf);
    end
  endtask

  task automatic sample_and_advance();
    @(negedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      cnt_out[i] = 0;
      cnt_in[i]  = 0;
      cnt_vl[i]  = 0;
    end
  endtask

  task automatic drive_random(input int i);
    in_v[i]    = 1'($urandom_range(0, 1));
    din[i]     = 8'($urandom);
    out_rdy[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_stream(input int i);
    in_v[i]    = 1'b1;
    din[i]     = 8'($urandom);
    out_rdy[i] = 1'b1;
  endtask

  initial begin
    w1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    w2 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 3; i++) begin
      pos[i] = 0;
      in_v[i] = 1'b0;
      din[i] = 8'h00;
      out_rdy[i] = 1'b0;
      for (int k = 0; k < 4; k++) vec[i][k] = 8'h00;
    end
    clear_counts();
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) drive_random(i);
      sample_and_advance();
    end
    rst_n = 1'b1;

    // Directed vector with continuous out_rdy; B and C stream continuously.
    clear_counts();
    for (int c = 0; c < 12; c++) begin
      in_v[0] = 1'b1;
      din[0] = (cnt_in[0] < 4) ? w1[cnt_in[0]] : 8'h00;
      out_rdy[0] = 1'b1;
      drive_stream(1);
      drive_stream(2);
      sample_and_advance();
    end
    check("p1_a_out_xfers", 32'(cnt_out[0]), 12);
    check("p1_a_in_xfers", 32'(cnt_in[0]), 4);
    check("p1_a_vec_last", 32'(cnt_vl[0]), 1);
    check("p1_b_in_xfers", 32'(cnt_in[1]), 12);
    check("p1_b_vec_last", 32'(cnt_vl[1]), 3);
    check("p1_c_in_xfers", 32'(cnt_in[2]), 3);
    check("p1_c_out_xfers", 32'(cnt_out[2]), 12);

    // out_rdy toggling 1-0 every cycle.
    clear_counts();
    for (int c = 0; c < 24; c++) begin
      in_v[0] = 1'b1;
      din[0] = (cnt_in[0] < 4) ? w2[cnt_in[0]] : 8'h00;
      out_rdy[0] = (c % 2 == 0);
      drive_random(1);
      drive_random(2);
      sample_and_advance();
    end
    check("p2_a_out_xfers", 32'(cnt_out[0]), 12);
    check("p2_a_vec_last", 32'(cnt_vl[0]), 1);

    // Input gaps of three cycles between words.
    clear_counts();
    for (int c = 0; c < 24; c++) begin
      in_v[0] = (c % 4 == 0);
      din[0] = 8'($urandom);
      out_rdy[0] = 1'b1;
      drive_random(1);
      drive_random(2);
      sample_and_advance();
    end
    check("p3_a_in_xfers", 32'(cnt_in[0]), 4);
    check("p3_a_out_xfers", 32'(cnt_out[0]), 12);

    // Reset in the middle of the second fold, word 1, then a fresh vector.
    clear_counts();
    begin
      int guard;
      guard = 0;
      while (pos[0] != 5 && guard < 50) begin
        in_v[0] = 1'b1;
        din[0] = (cnt_in[0] < 4) ? w1[cnt_in[0]] : 8'h00;
        out_rdy[0] = 1'b1;
        drive_random(1);
        drive_random(2);
        sample_and_advance();
        guard++;
      end
      check("p4_reach_mid_replay", 32'(pos[0]), 5);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive_random(i);
    sample_and_advance();
    rst_n = 1'b1;
    clear_counts();
    for (int c = 0; c < 12; c++) begin
      in_v[0] = 1'b1;
      din[0] = (cnt_in[0] < 4) ? w2[cnt_in[0]] : 8'h00;
      out_rdy[0] = 1'b1;
      drive_random(1);
      drive_random(2);
      sample_and_advance();
    end
    check("p4_a_out_xfers", 32'(cnt_out[0]), 12);
    check("p4_a_in_xfers", 32'(cnt_in[0]), 4);
    check("p4_a_vec_last", 32'(cnt_vl[0]), 1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 249) != 0);
      for (int i = 0; i < 3; i++) drive_random(i);
      sample_and_advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
